// File: rtl/uart_receiver_system.sv
// rtl/uart_receiver_system.sv - 8N1 UART receiver with valid/ack holding register and running CRC-8
module uart_receiver_system #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  CRC_POLY     = 8'h07
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_in,
    input  logic       ack,
    input  logic       clear_crc,
    output logic [7:0] data_out,
    output logic       valid,
    output logic [7:0] crc8,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned    CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic          meta_q, meta_d;
    logic          rx_s_q, rx_s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          accept_q, accept_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          valid_q, valid_d;
    logic [7:0]    crc_q, crc_d;
    logic          frame_error_q, frame_error_d;
    logic          overrun_q, overrun_d;

    logic          half_done;
    logic          full_done;
    logic          load;

    // Bytewise CRC-8, MSB first, no reflection and no final xor.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // State register and all datapath flops; synchroniser presets to the idle level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            meta_q        <= 1'b1;
            rx_s_q        <= 1'b1;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            accept_q      <= 1'b0;
            data_out_q    <= '0;
            valid_q       <= 1'b0;
            crc_q         <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            meta_q        <= meta_d;
            rx_s_q        <= rx_s_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            accept_q      <= accept_d;
            data_out_q    <= data_out_d;
            valid_q       <= valid_d;
            crc_q         <= crc_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state logic: mid-bit sampling decisions on the synchronised line.
    always_comb begin
        half_done = (cnt_q == HALF_LAST);
        full_done = (cnt_q == FULL_LAST);
        state_d   = state_q;
        case (state_q)
            S_IDLE:      if (!rx_s_q) state_d = S_START;
            S_START:     if (half_done) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA:      if (full_done && bit_q == 3'd7) state_d = S_STOP;
            S_STOP:      if (full_done) state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (rx_s_q) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath: counters, shift register, accept/handshake and CRC.
    always_comb begin
        meta_d        = data_in;
        rx_s_d        = meta_q;
        cnt_d         = cnt_q + CW'(1);
        bit_d         = bit_q;
        shift_d       = shift_q;
        accept_d      = 1'b0;
        frame_error_d = 1'b0;
        busy          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            S_START: begin
                if (half_done) cnt_d = '0;
            end
            S_DATA: begin
                if (full_done) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    shift_d = {rx_s_q, shift_q[7:1]};
                end
            end
            S_STOP: begin
                if (full_done) begin
                    cnt_d         = '0;
                    accept_d      = rx_s_q;
                    frame_error_d = !rx_s_q;
                end
            end
            default: cnt_d = '0;
        endcase

        // An ack in the accept cycle frees the holding register for the new byte.
        load       = accept_q && (!valid_q || ack);
        overrun_d  = accept_q && valid_q && !ack;
        data_out_d = load ? shift_q : data_out_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // Clear has priority so the byte accepted alongside it is not folded in.
        if (clear_crc) begin
            crc_d = '0;
        end else if (load) begin
            crc_d = crc8_byte(crc_q, shift_q);
        end else begin
            crc_d = crc_q;
        end
    end

    assign data_out    = data_out_q;
    assign valid       = valid_q;
    assign crc8        = crc_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_receiver_system.sv
// tb/tb_uart_receiver_system.sv - directed self-checking bench for uart_receiver_system
module tb_uart_receiver_system;

    localparam int CPB = 8;

    logic       clock;
    logic       reset;
    logic       data_in;
    logic       ack;
    logic       clear_crc;
    logic [7:0] data_out;
    logic       valid;
    logic [7:0] crc8;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int         checks    = 0;
    int         failures  = 0;
    int         rx_count  = 0;
    int         fe_count  = 0;
    int         ov_count  = 0;
    logic [7:0] rx_last   = 8'h00;
    logic       auto_ack  = 1'b0;

    uart_receiver_system #(
        .CLKS_PER_BIT(CPB),
        .CRC_POLY(8'h07)
    ) dut (
        .clock(clock),
        .reset(reset),
        .data_in(data_in),
        .ack(ack),
        .clear_crc(clear_crc),
        .data_out(data_out),
        .valid(valid),
        .crc8(crc8),
        .frame_error(frame_error),
        .overrun(overrun),
        .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Bit-serial reference CRC-8 (poly 0x07, init 0, MSB first).
    function automatic logic [7:0] ref_crc(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ b[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Event monitor: counts valid rises, frame errors and overruns.
    initial begin : monitor
        logic pv;
        pv = 1'b0;
        forever begin
            @(negedge clock);
            if (valid && !pv) begin
                rx_count = rx_count + 1;
                rx_last  = data_out;
            end
            if (frame_error) fe_count = fe_count + 1;
            if (overrun)     ov_count = ov_count + 1;
            pv = valid;
        end
    end

    // Consumer: one-cycle ack pulse the cycle after valid is seen.
    initial begin : acker
        ack = 1'b0;
        forever begin
            @(negedge clock);
            if (auto_ack && valid && !ack) ack = 1'b1;
            else                           ack = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        data_in = 1'b1;
    endtask

    task automatic pulse_clear;
        @(negedge clock);
        clear_crc = 1'b1;
        @(negedge clock);
        clear_crc = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle(3);
        checks++;
        if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++;
        if (crc8 !== 8'h00) begin failures++; $display("FAIL reset_crc8 got=%h exp=00", crc8); end
        checks++;
        if ({frame_error, overrun, busy} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {frame_error, overrun, busy});
        end
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_basic;
        logic [7:0] bytes [6];
        logic [7:0] exp_crc;
        int         c0;
        bytes = '{8'h00, 8'h01, 8'h02, 8'h80, 8'hFF, 8'h55};
        exp_crc  = 8'h00;
        auto_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c0 = rx_count;
            send_frame(bytes[i], 1'b1);
            idle(24);
            exp_crc = ref_crc(exp_crc, bytes[i]);
            checks++;
            if (rx_count !== c0 + 1) begin failures++; $display("FAIL basic_count[%0d] got=%0d exp=%0d", i, rx_count - c0, 1); end
            checks++;
            if (rx_last !== bytes[i]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, rx_last, bytes[i]); end
            if (i == 0) begin
                checks++;
                if (crc8 !== 8'h00) begin failures++; $display("FAIL basic_crc_after_00 got=%h exp=00", crc8); end
            end
            if (i == 1) begin
                checks++;
                if (crc8 !== 8'h07) begin failures++; $display("FAIL basic_crc_after_01 got=%h exp=07", crc8); end
            end
        end
        checks++;
        if (crc8 !== exp_crc) begin failures++; $display("FAIL basic_crc_final got=%h exp=%h", crc8, exp_crc); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after_ack got=%b exp=0", valid); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] s [9];
        int         c0, f0, o0;
        s  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        pulse_clear();
        checks++;
        if (crc8 !== 8'h00) begin failures++; $display("FAIL b2b_clear got=%h exp=00", crc8); end
        c0 = rx_count; f0 = fe_count; o0 = ov_count;
        for (int i = 0; i < 9; i++) send_frame(s[i], 1'b1);
        idle(24);
        checks++;
        if (crc8 !== 8'hF4) begin failures++; $display("FAIL b2b_crc got=%h exp=F4", crc8); end
        checks++;
        if (rx_count - c0 !== 9) begin failures++; $display("FAIL b2b_count got=%0d exp=9", rx_count - c0); end
        checks++;
        if ((fe_count - f0) + (ov_count - o0) !== 0) begin
            failures++; $display("FAIL b2b_errors got=%0d exp=0", (fe_count - f0) + (ov_count - o0));
        end
        checks++;
        if (rx_last !== 8'h39) begin failures++; $display("FAIL b2b_last got=%h exp=39", rx_last); end
    endtask

    task automatic test_frame_error;
        int c0, f0;
        c0 = rx_count; f0 = fe_count;
        send_frame(8'hA5, 1'b0);
        idle(24);
        checks++;
        if (fe_count - f0 !== 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", fe_count - f0); end
        checks++;
        if (rx_count !== c0 || valid !== 1'b0) begin
            failures++; $display("FAIL ferr_no_valid got=%0d/%b exp=0/0", rx_count - c0, valid);
        end
        checks++;
        if (crc8 !== 8'hF4) begin failures++; $display("FAIL ferr_crc got=%h exp=F4", crc8); end
        send_frame(8'h3C, 1'b1);
        idle(24);
        checks++;
        if (rx_count - c0 !== 1 || rx_last !== 8'h3C) begin
            failures++; $display("FAIL ferr_recover got=%0d/%h exp=1/3c", rx_count - c0, rx_last);
        end
        checks++;
        if (crc8 !== ref_crc(8'hF4, 8'h3C)) begin
            failures++; $display("FAIL ferr_recover_crc got=%h exp=%h", crc8, ref_crc(8'hF4, 8'h3C));
        end
    endtask

    task automatic test_glitch;
        int c0, f0;
        logic saw_busy;
        c0 = rx_count; f0 = fe_count;
        saw_busy = 1'b0;
        @(negedge clock);
        data_in = 1'b0;
        idle(2);
        data_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (busy) saw_busy = 1'b1;
        end
        idle(30);
        checks++;
        if (saw_busy !== 1'b1) begin failures++; $display("FAIL glitch_started got=%b exp=1", saw_busy); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL glitch_idle got=%b exp=0", busy); end
        checks++;
        if (rx_count !== c0 || fe_count !== f0) begin
            failures++; $display("FAIL glitch_events got=%0d/%0d exp=0/0", rx_count - c0, fe_count - f0);
        end
    endtask

    task automatic test_overrun;
        int o0;
        auto_ack = 1'b0;
        pulse_clear();
        o0 = ov_count;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(24);
        checks++;
        if (ov_count - o0 !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ov_count - o0); end
        checks++;
        if (valid !== 1'b1 || data_out !== 8'h11) begin
            failures++; $display("FAIL ovr_held got=%b/%h exp=1/11", valid, data_out);
        end
        checks++;
        if (crc8 !== 8'h77) begin failures++; $display("FAIL ovr_crc got=%h exp=77", crc8); end
        @(negedge clock);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || data_out !== 8'h11) begin
            failures++; $display("FAIL ovr_after_ack got=%b/%h exp=0/11", valid, data_out);
        end
        auto_ack = 1'b1;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        b = 8'h77;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({data_out, valid, crc8, frame_error, overrun, busy} !== 20'h0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h/%b/%h/%b%b%b exp=all0", data_out, valid, crc8, frame_error, overrun, busy);
        end
        data_in = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(4);
        send_frame(8'h12, 1'b1);
        idle(24);
        checks++;
        if (rx_last !== 8'h12) begin failures++; $display("FAIL midrst_data got=%h exp=12", rx_last); end
        checks++;
        if (crc8 !== 8'h7E) begin failures++; $display("FAIL midrst_crc got=%h exp=7e", crc8); end
    endtask

    initial begin
        reset     = 1'b0;
        data_in   = 1'b1;
        clear_crc = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_overrun();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
